bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_pkg.sv | 13 +
 rtl/rr_arb2.sv | 34 +++
 rtl/bram_arbiter.sv | 130 +++++++++++++
 tb/tb_bram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared state encoding and default sizes for the BRAM arbiter
package bram_pkg;

  // CLEAR sweeps zeros through the whole BRAM; RUN serves the two requesters
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_SIZE   = 4095;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with combinational grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0 favours req[0] on contention, 1 favours req[1]
  logic ptr;

  // Grant a lone requester outright; on contention follow the pointer
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After any grant, point at the requester that did not win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - shares one BRAM port between two requesters, with a zero-fill sweep
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_SIZE       = DEF_MEM_SIZE,
  parameter int ADDR_WIDTH     = $clog2(MEM_SIZE),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  clear_start,
  output logic                  init_done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  arb_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic [1:0]            req_vec;
  logic [1:0]            gnt_vec;
  logic                  run_live;

  // Requests only reach the arbiter in RUN and outside reset, so they are held off, never lost
  assign run_live = rst_n && (state == RUN);
  assign req_vec  = run_live ? {m1_req, m0_req} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vec),
    .gnt   (gnt_vec)
  );

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign init_done = (state == RUN);

  // The BRAM has a single read-data bus; rvalid tells each requester whose word it is
  assign m0_rdata = ram_q;
  assign m1_rdata = ram_q;

  // State and sweep counter register; reset always restarts the sweep from address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        state <= CLEAR;
      end else begin
        state <= RUN;
      end
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state and BRAM port drive: sweep zeros in CLEAR, forward the winner in RUN
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_d       = '0;
    case (state)
      CLEAR: begin
        ram_en   = rst_n;
        ram_we   = rst_n;
        ram_addr = clr_cnt;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        if (gnt_vec[0]) begin
          ram_en   = 1'b1;
          ram_we   = m0_we;
          ram_addr = m0_addr;
          ram_d    = m0_wdata;
        end else if (gnt_vec[1]) begin
          ram_en   = 1'b1;
          ram_we   = m1_we;
          ram_addr = m1_addr;
          ram_d    = m1_wdata;
        end
        if (clear_start) begin
          state_nxt = CLEAR;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Tag the read data returned next cycle with the requester granted a read this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= gnt_vec[0] & ~m0_we;
      m1_rvalid <= gnt_vec[1] & ~m1_we;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter
module tb_bram_arbiter;

  localparam int DW = 16;
  localparam int MS = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          clear_start = 1'b0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, init_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  bram_arbiter #(
    .DATA_WIDTH     (DW),
    .MEM_SIZE       (MS),
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .clear_start (clear_start),
    .init_done   (init_done),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_d       (ram_d),
    .ram_q       (ram_q)
  );

  always #5 clk = ~clk;

  // Read-first single-port BRAM with one cycle of read latency
  logic [DW-1:0] mem [MS];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: sweep progress, favoured requester, pending read, expected contents
  bit            m_clearing;
  int            m_idx;
  int            m_fav;
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] shadow [MS];
  int            last_w = -1;

  // Values seen at the last sampling point, for hand-written checks
  logic          obs_g0, obs_g1, obs_en, obs_we, obs_rv0, obs_rv1, obs_done;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rd0, obs_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (m_clearing) return -1;
    if (m0_req && m1_req) return m_fav;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_clearing = 1'b1;
    m_idx      = 0;
    m_fav      = 0;
    m_rv0      = 1'b0;
    m_rv1      = 1'b0;
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance the model
  task automatic cycle();
    int            w;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d;
    @(negedge clk);
    w = winner();
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_d = '0;
    if (m_clearing) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = m_idx[AW-1:0];
    end else if (w == 0) begin
      e_en = 1'b1; e_we = m0_we; e_addr = m0_addr; e_d = m0_wdata;
    end else if (w == 1) begin
      e_en = 1'b1; e_we = m1_we; e_addr = m1_addr; e_d = m1_wdata;
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_d", 32'(ram_d), 32'(e_d));
    chk("init_done", 32'(init_done), 32'(!m_clearing));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(m_rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(m_rv1));
    if (m_rv0) chk("m0_rdata", 32'(m0_rdata), 32'(m_rdata));
    if (m_rv1) chk("m1_rdata", 32'(m1_rdata), 32'(m_rdata));
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_en = ram_en; obs_we = ram_we;
    obs_addr = ram_addr; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_rd1 = m1_rdata; obs_done = init_done;
    last_w = w;
    @(posedge clk);
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    if (m_clearing) begin
      shadow[m_idx] = '0;
      if (m_idx == MS - 1) begin
        m_clearing = 1'b0;
        m_idx      = 0;
      end else begin
        m_idx++;
      end
    end else begin
      if (w == 0) begin
        if (m0_we) shadow[m0_addr] = m0_wdata;
        else begin m_rv0 = 1'b1; m_rdata = shadow[m0_addr]; end
        m_fav = 1;
      end else if (w == 1) begin
        if (m1_we) shadow[m1_addr] = m1_wdata;
        else begin m_rv1 = 1'b1; m_rdata = shadow[m1_addr]; end
        m_fav = 0;
      end
      if (clear_start) begin
        m_clearing = 1'b1;
        m_idx      = 0;
      end
    end
    #1;
  endtask

  typedef struct {
    logic          r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, en, we;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tv [10];

  initial begin
    // Arbitration vectors, applied with the pointer favouring m1 on entry
    tv[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 16'h0000, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2};
    tv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5};
    tv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    tv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5};
    tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    tv[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd8, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9};
    tv[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};

    // Reset: a pending request must not be granted while rst_n is low
    model_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;

    // Sweep of 16 addresses while m0 holds a read; grant lands on the first RUN cycle
    for (int i = 0; i < MS; i++) begin
      cycle();
      chk("clr_addr", 32'(obs_addr), 32'(i));
      chk("clr_held_off", 32'(obs_g0), 32'd0);
    end
    cycle();
    chk("first_run_done", 32'(obs_done), 32'd1);
    chk("first_run_gnt", 32'(obs_g0), 32'd1);
    m0_req = 1'b0;
    cycle();
    chk("held_read_rvalid", 32'(obs_rv0), 32'd1);
    chk("held_read_rdata", 32'(obs_rd0), 32'd0);

    // m0 writes 0xBEEF to address 5 and reads it back
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'd5; m0_wdata = 16'hBEEF;
    cycle();
    m0_we = 1'b0;
    cycle();
    chk("beef_rd_gnt", 32'(obs_g0), 32'd1);
    m0_req = 1'b0;
    cycle();
    chk("beef_rvalid", 32'(obs_rv0), 32'd1);
    chk("beef_rdata", 32'(obs_rd0), 32'hBEEF);
    chk("beef_m1_rvalid", 32'(obs_rv1), 32'd0);

    // Table-driven arbitration, including six contended reads alternating m0,m1
    for (int i = 0; i < 10; i++) begin
      m0_req = tv[i].r0; m1_req = tv[i].r1; m0_we = tv[i].w0; m1_we = tv[i].w1;
      m0_addr = tv[i].a0; m1_addr = tv[i].a1; m0_wdata = tv[i].d0; m1_wdata = tv[i].d1;
      cycle();
      chk("tbl_gnt0", 32'(obs_g0), 32'(tv[i].g0));
      chk("tbl_gnt1", 32'(obs_g1), 32'(tv[i].g1));
      chk("tbl_ram_en", 32'(obs_en), 32'(tv[i].en));
      chk("tbl_ram_we", 32'(obs_we), 32'(tv[i].we));
      chk("tbl_ram_addr", 32'(obs_addr), 32'(tv[i].addr));
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cycle();

    // clear_start while m1 reads address 3: old data still returned, then a full sweep
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'd3; m1_wdata = 16'h1234;
    cycle();
    m1_we = 1'b0; clear_start = 1'b1;
    cycle();
    chk("cs_read_gnt", 32'(obs_g1), 32'd1);
    m1_req = 1'b0; clear_start = 1'b0;
    cycle();
    chk("cs_rvalid", 32'(obs_rv1), 32'd1);
    chk("cs_rdata", 32'(obs_rd1), 32'h1234);
    chk("cs_in_clear", 32'(obs_done), 32'd0);
    for (int i = 1; i < MS; i++) begin
      clear_start = (i == 4);
      cycle();
    end
    clear_start = 1'b0;
    m1_req = 1'b1; m1_addr = 4'd3;
    cycle();
    chk("post_clear_gnt", 32'(obs_g1), 32'd1);
    m1_req = 1'b0;
    cycle();
    chk("post_clear_rdata", 32'(obs_rd1), 32'd0);

    // Reset in the middle of a sweep at address 9
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    #2;
    chk("mid_clear_addr", 32'(ram_addr), 32'd9);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd9;
    rst_n = 1'b0;
    #1;
    chk("arst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("arst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("arst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    chk("arst_init_done", 32'(init_done), 32'd0);
    chk("arst_ram_addr", 32'(ram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < MS; i++) begin
      cycle();
      chk("restart_addr", 32'(obs_addr), 32'(i));
    end
    cycle();
    chk("restart_gnt", 32'(obs_g0), 32'd1);
    m0_req = 1'b0;
    cycle();
    chk("restart_rdata", 32'(obs_rd0), 32'd0);

    // Randomized traffic: requests held until granted, occasional clear_start
    for (int n = 0; n < 400; n++) begin
      if (!m0_req || last_w == 0) begin
        m0_req   = ($urandom_range(0, 2) != 0);
        m0_we    = 1'($urandom_range(0, 1));
        m0_addr  = AW'($urandom_range(0, MS - 1));
        m0_wdata = DW'($urandom);
      end
      if (!m1_req || last_w == 1) begin
        m1_req   = ($urandom_range(0, 2) != 0);
        m1_we    = 1'($urandom_range(0, 1));
        m1_addr  = AW'($urandom_range(0, MS - 1));
        m1_wdata = DW'($urandom);
      end
      clear_start = ($urandom_range(0, 59) == 0);
      cycle();
    end
    m0_req = 1'b0; m1_req = 1'b0; clear_start = 1'b0;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
